// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter
// (state enum, digit width, add-3 correction threshold and offset).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;

    localparam logic [DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_OFFSET    = 4'd3;

endpackage

// File: rtl/bcd_add3_adj.sv
// Combinational double-dabble correction for one BCD digit: digits of five
// or more get three added so the following left shift carries correctly.
module bcd_add3_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESHOLD) begin
            o_digit = i_digit + ADJ_OFFSET;
        end
    end

endmodule

// File: rtl/bcd_serial_conv.sv
// Serial (one bit per cycle) binary-to-BCD converter with IDLE/SHIFT/DONE FSM.
// Define BCD_SERIAL_CONV_LZB_EN to compile in leading-zero blanking flags.
module bcd_serial_conv
    import bcd_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [2:0]       blank,
    output logic             done
);

    localparam int SCRATCH_W = NUM_DIGITS * DIGIT_W;
    localparam int COUNT_W   = 4;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [WIDTH-1:0]       r_bin;
    logic [SCRATCH_W-1:0]   r_scratch;
    logic [SCRATCH_W-1:0]   w_adjusted;
    logic [SCRATCH_W-1:0]   w_shifted;
    logic [COUNT_W-1:0]     r_count;
    logic [DIGIT_W-1:0]     r_ones;
    logic [DIGIT_W-1:0]     r_tens;
    logic [DIGIT_W-1:0]     r_hundreds;
    logic                   w_lastShift;
    logic                   w_loadDigits;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_add3_adj u_adj (
            .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adjusted[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected scratch shifts left; the captured value's MSB enters ones bit 0.
    assign w_shifted    = (w_adjusted << 1) | SCRATCH_W'(r_bin[WIDTH-1]);
    assign w_lastShift  = (r_count == LAST_COUNT);
    assign w_loadDigits = (r_state == SHIFT) && w_lastShift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = SHIFT;
            SHIFT:   if (w_lastShift) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE);
        done     = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_ones     <= '0;
            r_tens     <= '0;
            r_hundreds <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin     <= bin_in;
                        r_scratch <= '0;
                        r_count   <= '0;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_shifted;
                    r_bin     <= r_bin << 1;
                    r_count   <= r_count + 1'b1;
                    if (w_lastShift) begin
                        r_ones     <= w_shifted[0*DIGIT_W +: DIGIT_W];
                        r_tens     <= w_shifted[1*DIGIT_W +: DIGIT_W];
                        r_hundreds <= w_shifted[2*DIGIT_W +: DIGIT_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ones     = r_ones;
    assign tens     = r_tens;
    assign hundreds = r_hundreds;

`ifdef BCD_SERIAL_CONV_LZB_EN
    logic [2:0] r_blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blank <= 3'b000;
        end else if (w_loadDigits) begin
            r_blank[2] <= (w_shifted[2*DIGIT_W +: DIGIT_W] == '0);
            r_blank[1] <= (w_shifted[2*DIGIT_W +: DIGIT_W] == '0) &&
                          (w_shifted[1*DIGIT_W +: DIGIT_W] == '0);
            r_blank[0] <= 1'b0;
        end
    end

    assign blank = r_blank;
`else
    logic w_unusedLoad;
    assign w_unusedLoad = w_loadDigits;
    assign blank = {2'b00, w_unusedLoad & 1'b0};
`endif

endmodule

// File: tb/tb_bcd_serial_conv.sv
// Self-checking bench for bcd_serial_conv: directed scenarios, an exhaustive
// sweep and random conversions against an arithmetic decimal-digit model.
module tb_bcd_serial_conv;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 20;
`ifdef BCD_SERIAL_CONV_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] bin_in;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ones;
    logic [3:0]       tens;
    logic [3:0]       hundreds;
    logic [2:0]       blank;
    logic             done;

    int assertCount = 0;
    int failCount   = 0;
    int doneSeen    = 0;
    int lastValue   = 0;

    bcd_serial_conv #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ones     (ones),
        .tens     (tens),
        .hundreds (hundreds),
        .blank    (blank),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) doneSeen++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decimal digits {hundreds, tens, ones} from plain integer arithmetic.
    function automatic logic [11:0] refDigits(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] refBlank(input int v);
        if (!LZB) return 3'b000;
        return {v < 100, v < 10, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_and_wait(input int value, output int cycles);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < TIMEOUT) begin
            tick();
            w++;
        end
        bin_in   = WIDTH'(value);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles   = 0;
        while (done !== 1'b1 && cycles < TIMEOUT) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        tick();
        tick();
        assertCount++;
        if ({in_ready, done} !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL reset_ctrl: got ready/done=%b expected 10", {in_ready, done});
        end
        assertCount++;
        if ({hundreds, tens, ones, blank} !== 15'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got digits=%h blank=%b expected 000/000",
                     {hundreds, tens, ones}, blank);
        end
        rst_n = 1'b1;
        tick();
        assertCount++;
        if (in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed(input int value, input string name);
        int cycles;
        start_and_wait(value, cycles);
        assertCount++;
        if (cycles != WIDTH) begin
            failCount++;
            $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", name, cycles, WIDTH);
        end
        assertCount++;
        if ({hundreds, tens, ones} !== refDigits(value)) begin
            failCount++;
            $display("[TB] FAIL %s_digits: got %h expected %h", name,
                     {hundreds, tens, ones}, refDigits(value));
        end
        assertCount++;
        if (blank !== refBlank(value)) begin
            failCount++;
            $display("[TB] FAIL %s_blank: got %b expected %b", name, blank, refBlank(value));
        end
        tick();
        assertCount++;
        if ({done, in_ready} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL %s_pulse: got done/ready=%b expected 01", name, {done, in_ready});
        end
        lastValue = value;
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{9, 10, 100};
        int cycles;
        bin_in   = WIDTH'(vals[0]);
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            cycles = 0;
            while (done !== 1'b1 && cycles < TIMEOUT) begin
                tick();
                cycles++;
            end
            assertCount++;
            if (cycles != WIDTH) begin
                failCount++;
                $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, cycles, WIDTH);
            end
            assertCount++;
            if ({hundreds, tens, ones, blank} !== {refDigits(vals[i]), refBlank(vals[i])}) begin
                failCount++;
                $display("[TB] FAIL b2b_result[%0d]: got %h/%b expected %h/%b", i,
                         {hundreds, tens, ones}, blank, refDigits(vals[i]), refBlank(vals[i]));
            end
            if (i < 2) begin
                bin_in = WIDTH'(vals[i+1]);
                tick();
                assertCount++;
                if ({in_ready, done} !== 2'b10) begin
                    failCount++;
                    $display("[TB] FAIL b2b_idle[%0d]: got ready/done=%b expected 10", i, {in_ready, done});
                end
                tick();
                assertCount++;
                if (in_ready !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL b2b_accept[%0d]: got ready=%b expected 0", i, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        lastValue = vals[2];
    endtask

    task automatic test_ignore_during_shift();
        int cycles;
        while (in_ready !== 1'b1) tick();
        bin_in   = WIDTH'(137);
        in_valid = 1'b1;
        tick();
        cycles = 0;
        while (done !== 1'b1 && cycles < TIMEOUT) begin
            assertCount++;
            if (in_ready !== 1'b0 || {hundreds, tens, ones} !== refDigits(lastValue)) begin
                failCount++;
                $display("[TB] FAIL shift_hold[%0d]: got ready=%b digits=%h expected 0/%h",
                         cycles, in_ready, {hundreds, tens, ones}, refDigits(lastValue));
            end
            bin_in   = WIDTH'($urandom_range(0, 255));
            in_valid = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        assertCount++;
        if (cycles != WIDTH || {hundreds, tens, ones} !== refDigits(137)) begin
            failCount++;
            $display("[TB] FAIL shift_result: got %0d cycles digits=%h expected %0d/%h",
                     cycles, {hundreds, tens, ones}, WIDTH, refDigits(137));
        end
        tick();
        tick();
        assertCount++;
        if ({in_ready, done} !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL shift_no_extra: got ready/done=%b expected 10", {in_ready, done});
        end
        lastValue = 137;
    endtask

    task automatic test_reset_abort();
        int doneBefore;
        doneBefore = doneSeen;
        bin_in     = WIDTH'(200);
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        assertCount++;
        if (in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL abort_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 12; i++) tick();
        assertCount++;
        if (doneSeen != doneBefore) begin
            failCount++;
            $display("[TB] FAIL abort_done: got %0d pulses expected 0", doneSeen - doneBefore);
        end
        assertCount++;
        if ({hundreds, tens, ones, blank} !== 15'd0) begin
            failCount++;
            $display("[TB] FAIL abort_outputs: got digits=%h blank=%b expected 000/000",
                     {hundreds, tens, ones}, blank);
        end
        lastValue = 0;
    endtask

    task automatic test_exhaustive();
        int doneBefore;
        int cycles;
        doneBefore = doneSeen;
        for (int v = 0; v < (1 << WIDTH); v++) begin
            start_and_wait(v, cycles);
            assertCount++;
            if ({hundreds, tens, ones, blank} !== {refDigits(v), refBlank(v)}) begin
                failCount++;
                $display("[TB] FAIL sweep[%0d]: got %h/%b expected %h/%b", v,
                         {hundreds, tens, ones}, blank, refDigits(v), refBlank(v));
            end
        end
        tick();
        assertCount++;
        if (doneSeen - doneBefore != (1 << WIDTH)) begin
            failCount++;
            $display("[TB] FAIL sweep_done_count: got %0d expected %0d",
                     doneSeen - doneBefore, 1 << WIDTH);
        end
    endtask

    task automatic test_random();
        int v;
        int cycles;
        for (int n = 0; n < 24; n++) begin
            v = int'($urandom_range(0, (1 << WIDTH) - 1));
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                bin_in = WIDTH'($urandom_range(0, 255));
                tick();
            end
            start_and_wait(v, cycles);
            assertCount++;
            if (cycles != WIDTH || {hundreds, tens, ones, blank} !== {refDigits(v), refBlank(v)}) begin
                failCount++;
                $display("[TB] FAIL random[%0d]: value %0d got %0d cycles %h/%b expected %0d %h/%b",
                         n, v, cycles, {hundreds, tens, ones}, blank, WIDTH, refDigits(v), refBlank(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed(255, "max");
        test_directed(0, "zero");
        test_back_to_back();
        test_ignore_during_shift();
        test_reset_abort();
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_serial_conv.md
BCD_SERIAL_CONV -- requirements
Module: bcd_serial_conv

Interface
REQ-001 Parameter WIDTH, default 8, binary input width; legal range 4..8.
REQ-002 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 Port bin_in, input, WIDTH, unsigned binary value from the upstream counter.
REQ-005 Port in_valid, input, 1, bin_in holds a value to convert.
REQ-006 Port in_ready, output, 1, high only in IDLE; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-007 Port ones, output, 4, BCD units digit feeding the 7-segment decoder.
REQ-008 Port tens, output, 4, BCD tens digit.
REQ-009 Port hundreds, output, 4, BCD hundreds digit; range 0..2.
REQ-010 Port blank, output, 3, per-digit blanking flags {hundreds, tens, ones}.
REQ-011 Port done, output, 1, one-cycle pulse marking a new result on the digit outputs.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: on a transfer, the block SHALL capture bin_in, zero the scratch digits, set the shift count to 0, and go to SHIFT.
REQ-014 SHIFT, each cycle: any scratch digit >=5 SHALL get +3, then the full scratch SHALL shift left 1, with the captured MSB entering ones bit 0.
- The count SHALL increment once per SHIFT cycle.
REQ-015 SHIFT SHALL last exactly WIDTH cycles.
- On the final shift edge, the corrected digits SHALL load into ones, tens, hundreds and blank.
- The FSM SHALL then go to DONE.
REQ-016 DONE: done SHALL be 1 for that single cycle, in_ready SHALL be 0, and the FSM SHALL return to IDLE on the next edge.
REQ-017 Latency:
- Transfer at edge k; done high in the cycle after edge k+WIDTH.
- Next transfer possible no earlier than edge k+WIDTH+2.
REQ-018 in_valid while in SHIFT or DONE SHALL be ignored, and bin_in changes during conversion SHALL NOT affect the result.
REQ-019 Digit outputs SHALL hold the last result until the next DONE load, and SHALL NOT change mid-conversion.
REQ-020 Digits SHALL satisfy hundreds*100 + tens*10 + ones == captured value for every value 0..2^WIDTH-1.
REQ-021 in_valid held high continuously SHALL produce back-to-back conversions with one IDLE cycle between them.

Reset
REQ-022 With rst_n=0 at an edge, the block SHALL set:
- state=IDLE, scratch=0, count=0;
- ones=tens=hundreds=0, blank=3'b000, done=0.
REQ-023 Reset asserted during SHIFT or DONE SHALL abort the conversion with no done pulse and no digit update.
REQ-024 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-025 Macro BCD_SERIAL_CONV_LZB_EN compiles in leading-zero blanking.
REQ-026 With BCD_SERIAL_CONV_LZB_EN defined, blank SHALL be loaded at the REQ-015 load edge as follows:
- blank[2] = (hundreds==0);
- blank[1] = (hundreds==0 && tens==0);
- blank[0] = 0 always.
REQ-027 Without BCD_SERIAL_CONV_LZB_EN, blank SHALL be tied to 3'b000; the port remains present and all other behaviour is identical.

Structure
REQ-028 Shared package bcd_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT, DONE);
- the digit width constant (4);
- the correction threshold (5) and offset (3).
REQ-029 Per-digit correction SHALL be one combinational sub-module, bcd_add3_adj, instantiated once per scratch digit; all sequencing stays in bcd_serial_conv.

Verification
REQ-030 Reset, then transfer bin_in=8'd255 -> done 8 cycles after the transfer edge; hundreds=2, tens=5, ones=5; blank=000.
REQ-031 Transfer 8'd0 -> digits 0,0,0; blank=110 with LZB_EN defined, 000 without.
REQ-032 Transfer 8'd9, then 8'd10, then 8'd100 with in_valid held high:
- results 0/0/9, 0/1/0, 1/0/0;
- exactly one IDLE cycle between each done and the next transfer;
- blank with LZB_EN: 110, 100, 000.
REQ-033 Transfer 8'd137, toggle bin_in and in_valid during SHIFT -> result 1/3/7; no extra transfer accepted.
REQ-034 Transfer 8'd200, assert rst_n=0 at the 4th SHIFT cycle -> no done pulse, all digits 0, in_ready=1 one cycle after release.
REQ-035 Exhaustive sweep 0..255 against the REQ-020 reference -> zero mismatches; done count equals transfer count.
